// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory model with a fixed-latency,
// in-order completion pipeline and a bounded count of outstanding requests.
//
// Handshake: a request is presented on proc2mem_command/addr/data and is
// taken at the next posedge exactly when mem2proc_response is non-zero in
// that same cycle. A zero response means the requester must hold or
// re-present the request later. Completions are announced by a non-zero
// mem2proc_tag (with mem2proc_data for loads) for exactly one cycle.
module mem_responder #(
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int MEM_WORDS       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [31:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [31:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int          IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [4:0]  MAX_OUT = 5'(MAX_OUTSTANDING);
  localparam logic [30:0] WORDS   = 31'(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  // Delay line: stage 0 is loaded at the accepting edge, the last stage
  // drives the completion outputs directly.
  logic        pipe_valid [LATENCY];
  logic [3:0]  pipe_tag   [LATENCY];
  logic [31:0] pipe_data  [LATENCY];

  logic [3:0]       next_tag;
  logic [3:0]       in_flight;
  logic [3:0]       in_flight_next;
  logic [29:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             is_load;
  logic             is_store;
  logic             legal;
  logic             retire;
  logic             accept;

  // Request decode, occupancy and the combinational accept decision.
  always_comb begin
    word_idx       = proc2mem_addr[31:2];
    mem_idx        = word_idx[IDX_W-1:0];
    is_load        = (proc2mem_command == BUS_LOAD);
    is_store       = (proc2mem_command == BUS_STORE);
    legal          = (is_load || is_store) && (proc2mem_addr[1:0] == 2'b00)
                     && ({1'b0, word_idx} < WORDS);
    retire         = pipe_valid[LATENCY-1];
    // A completion retiring this cycle frees its slot for a same-cycle accept.
    in_flight_next = in_flight - {3'b000, retire};
    accept         = !rst && legal && ({1'b0, in_flight_next} < MAX_OUT);
    mem2proc_response = accept ? next_tag : 4'd0;
  end

  // Tag allocator and outstanding-request counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_tag  <= 4'd1;
      in_flight <= 4'd0;
    end else begin
      if (accept) begin
        // Tag 0 is reserved for "nothing", so wrap 15 back to 1.
        next_tag  <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
        in_flight <= in_flight_next + 4'd1;
      end else begin
        in_flight <= in_flight_next;
      end
    end
  end

  // Completion delay line; empty slots carry tag 0 and data 0 so the
  // outputs are idle without extra gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_tag[i]   <= 4'd0;
        pipe_data[i]  <= 32'd0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_tag[0]   <= accept ? next_tag : 4'd0;
      pipe_data[0]  <= (accept && is_load) ? mem[mem_idx] : 32'd0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  // Storage array; deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && is_store) begin
      mem[mem_idx] <= proc2mem_data;
    end
  end

  assign mem2proc_tag  = pipe_tag[LATENCY-1];
  assign mem2proc_data = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector tables for the main flows, hand-written
// sequences for mid-operation reset and tag wrap, and a completion
// scoreboard keyed by expected completion cycle.
module tb_mem_responder;

  localparam int LAT = 4;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;
  localparam logic [1:0] C_BAD   = 2'd3;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  exp_resp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  resp;
  logic [31:0] rdata;
  logic [3:0]  tag;

  logic [1:0]  b_cmd;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_resp;
  logic [31:0] b_rdata;
  logic [3:0]  b_tag;

  mem_responder dut (
    .clk               (clk),
    .rst               (rst),
    .proc2mem_command  (cmd),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .mem2proc_response (resp),
    .mem2proc_data     (rdata),
    .mem2proc_tag      (tag)
  );

  mem_responder #(.LATENCY(14), .MAX_OUTSTANDING(15), .MEM_WORDS(64)) dut_big (
    .clk               (clk),
    .rst               (rst),
    .proc2mem_command  (b_cmd),
    .proc2mem_addr     (b_addr),
    .proc2mem_data     (b_wdata),
    .mem2proc_response (b_resp),
    .mem2proc_data     (b_rdata),
    .mem2proc_tag      (b_tag)
  );

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  // {due_cycle[31:0], tag[3:0], data[31:0]}
  logic [67:0] exp_q[$];
  logic [31:0] ref_mem [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst   = 1'b1;
    cmd   = C_LOAD;
    addr  = 32'h10;
    wdata = 32'h0;
    b_cmd = C_NONE; b_addr = 32'h0; b_wdata = 32'h0;
    #1;
    check("rst_response", {28'b0, resp}, 32'h0);
    check("rst_tag", {28'b0, tag}, 32'h0);
    check("rst_data", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmd = C_NONE;
    exp_q.delete();
    cyc = 0;
  endtask

  // One cycle: drive a request, check the accept tag and the completion port.
  task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] er);
    logic [67:0] head;
    logic [31:0] ld;
    cmd = c; addr = a; wdata = d;
    @(negedge clk);
    check("response", {28'b0, resp}, {28'b0, er});
    if (exp_q.size() > 0 && exp_q[0][67:36] == 32'(cyc)) begin
      head = exp_q.pop_front();
      check("cpl_tag", {28'b0, tag}, {28'b0, head[35:32]});
      check("cpl_data", rdata, head[31:0]);
    end else begin
      check("idle_tag", {28'b0, tag}, 32'h0);
      check("idle_data", rdata, 32'h0);
    end
    if (er != 4'd0) begin
      ld = 32'h0;
      if (c == C_LOAD) ld = ref_mem[int'(a[31:2])];
      exp_q.push_back({32'(cyc + LAT), er, ld});
      if (c == C_STORE) ref_mem[int'(a[31:2])] = d;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- test ----------------
  vec_t t_basic [14];
  vec_t t_full  [12];

  initial begin
    // Store then load-back, illegal requests, top word boundary.
    t_basic[0]  = '{C_STORE, 32'h10,   32'hDEADBEEF, 4'd1};
    t_basic[1]  = '{C_LOAD,  32'h10,   32'h0,        4'd2};
    t_basic[2]  = '{C_NONE,  32'h0,    32'h0,        4'd0};
    t_basic[3]  = '{C_NONE,  32'h0,    32'h0,        4'd0};
    t_basic[4]  = '{C_LOAD,  32'h3,    32'h0,        4'd0};
    t_basic[5]  = '{C_LOAD,  32'h1000, 32'h0,        4'd0};
    t_basic[6]  = '{C_BAD,   32'h10,   32'h0,        4'd0};
    t_basic[7]  = '{C_STORE, 32'hFFC,  32'h12345678, 4'd3};
    t_basic[8]  = '{C_LOAD,  32'hFFC,  32'h0,        4'd4};
    for (int i = 9; i < 14; i++) t_basic[i] = '{C_NONE, 32'h0, 32'h0, 4'd0};

    // Back-to-back loads against MAX_OUTSTANDING=2.
    t_full[0] = '{C_LOAD, 32'h10, 32'h0, 4'd1};
    t_full[1] = '{C_LOAD, 32'h10, 32'h0, 4'd2};
    t_full[2] = '{C_LOAD, 32'h10, 32'h0, 4'd0};
    t_full[3] = '{C_LOAD, 32'h10, 32'h0, 4'd0};
    t_full[4] = '{C_LOAD, 32'h10, 32'h0, 4'd3};
    t_full[5] = '{C_LOAD, 32'h10, 32'h0, 4'd4};
    for (int i = 6; i < 12; i++) t_full[i] = '{C_NONE, 32'h0, 32'h0, 4'd0};

    do_reset();
    for (int i = 0; i < 14; i++)
      step(t_basic[i].cmd, t_basic[i].addr, t_basic[i].data, t_basic[i].exp_resp);
    check("basic_drained", 32'(exp_q.size()), 32'h0);

    // Array survives reset: the loads return the earlier store.
    do_reset();
    for (int i = 0; i < 12; i++)
      step(t_full[i].cmd, t_full[i].addr, t_full[i].data, t_full[i].exp_resp);
    check("full_drained", 32'(exp_q.size()), 32'h0);

    // Mid-operation reset with tags 1 and 2 in flight.
    do_reset();
    step(C_STORE, 32'h20, 32'h55, 4'd1);
    step(C_LOAD,  32'h10, 32'h0,  4'd2);
    rst = 1'b1;
    cmd = C_LOAD; addr = 32'h20;
    #1;
    check("midrst_response", {28'b0, resp}, 32'h0);
    check("midrst_tag", {28'b0, tag}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmd = C_NONE;
    exp_q.delete();
    cyc = 4;
    while (cyc <= 10) step(C_NONE, 32'h0, 32'h0, 4'd0);
    step(C_LOAD, 32'h20, 32'h0, 4'd1);
    for (int i = 0; i < 5; i++) step(C_NONE, 32'h0, 32'h0, 4'd0);
    check("midrst_drained", 32'(exp_q.size()), 32'h0);

    // Tag wrap on the deep instance: 16 stores back to back.
    do_reset();
    for (int i = 0; i < 31; i++) begin
      logic [3:0] et;
      b_cmd   = (i < 16) ? C_STORE : C_NONE;
      b_addr  = 32'(i * 4);
      b_wdata = $urandom_range(0, 32'hFFFF);
      @(negedge clk);
      if (i < 16) check("big_response", {28'b0, b_resp}, 32'((i % 15) + 1));
      et = (i >= 14 && i <= 29) ? 4'(((i - 14) % 15) + 1) : 4'd0;
      check("big_tag", {28'b0, b_tag}, {28'b0, et});
      check("big_data", b_rdata, 32'h0);
      @(posedge clk);
      #1;
    end
    b_cmd = C_NONE;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to completion tag; legal range 1..14.
REQ-002 Parameter MAX_OUTSTANDING, default 2: maximum accepted requests not yet completed; legal range 1..15.
REQ-003 Parameter MEM_WORDS, default 1024: number of 32-bit storage words.
REQ-004 clk  input  1  system clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 proc2mem_command  input  2  `BUS_NONE=0`, `BUS_LOAD=1`, `BUS_STORE=2`; value 3 is treated as `BUS_NONE`.
REQ-007 proc2mem_addr  input  32  byte address of the request.
REQ-008 proc2mem_data  input  32  store data.
REQ-009 mem2proc_response  output  4  combinational accept tag, 1..15; 0 means not accepted.
REQ-010 mem2proc_data  output  32  registered load data for the completing tag.
REQ-011 mem2proc_tag  output  4  registered completion tag; 0 means no completion this cycle.

Function
REQ-012 Word index SHALL be proc2mem_addr[31:2].
REQ-013 A request is legal only if all of these hold:
- command is LOAD or STORE;
- addr[1:0]==0;
- word index < MEM_WORDS.
REQ-014 in_flight_next SHALL equal in_flight minus 1 if a completion retires this cycle, else in_flight.
REQ-015 A legal request SHALL be accepted when in_flight_next < MAX_OUTSTANDING.
- When accepted, mem2proc_response SHALL equal next_tag in the same cycle.
- When not accepted (illegal or full), mem2proc_response SHALL be 0.
REQ-016 On each accepting posedge:
- next_tag SHALL advance 1→2→…→15→1; 0 is never issued;
- in_flight SHALL become in_flight_next+1.
On non-accepting posedges, in_flight SHALL become in_flight_next.
REQ-017 An accepted STORE SHALL write proc2mem_data to the array at the accepting posedge.
REQ-018 An accepted LOAD SHALL capture array contents at the accepting posedge.
- A load accepted the cycle after a store to the same word SHALL return the stored value.
REQ-019 Each accepted request SHALL enter a LATENCY-stage delay line holding {valid, tag, data}; stores carry data 0.
REQ-020 A request accepted in cycle n SHALL drive mem2proc_tag and mem2proc_data in cycle n+LATENCY, for exactly one cycle.
- That cycle counts as the request's retire cycle for REQ-014.
REQ-021 When no completion occurs, mem2proc_tag SHALL be 0 and mem2proc_data SHALL be 0.
REQ-022 Completions SHALL occur in acceptance order; at most one per cycle.
REQ-023 Rejected requests SHALL leave array, next_tag, in_flight and the delay line unchanged; the requester re-presents them.
REQ-024 Simultaneous retire and accept in one cycle SHALL be permitted and leave in_flight unchanged.

Reset
REQ-025 While rst is high, the following SHALL be forced asynchronously:
- next_tag=1, in_flight=0, all delay-line valid bits=0;
- mem2proc_tag=0, mem2proc_data=0, mem2proc_response=0.
REQ-026 Reset mid-operation SHALL discard all in-flight requests; no completion for them SHALL appear after rst deasserts.
REQ-027 Array contents SHALL NOT be altered by reset.
- Stores accepted before reset remain visible.
REQ-028 The first request after reset deasserts SHALL receive tag 1.

Verification
REQ-029 STORE 0x0000_0010 data 0xDEADBEEF in cycle 0, LOAD 0x10 in cycle 1 →
- response 1 then 2;
- mem2proc_tag=1/data=0 in cycle 4;
- tag=2/data=0xDEADBEEF in cycle 5.
REQ-030 LOAD every cycle, cycles 0–5, with MAX_OUTSTANDING=2 →
- accepted in cycles 0, 1, 4, 5 (tags 1, 2, 3, 4);
- response 0 in cycles 2, 3;
- completions in cycles 4, 5, 8, 9.
REQ-031 LOAD addr 0x3 and LOAD addr 4*MEM_WORDS → response 0 in both cycles; no completion at any later cycle; next tag issued is unchanged.
REQ-032 Issue 16 accepted requests with MAX_OUTSTANDING=15, LATENCY=14 → tags 1..15 then 1; no tag 0 is ever issued.
REQ-033 Assert rst in cycle 2 with tags 1 and 2 in flight; STORE 0x20=0x55 was accepted before reset →
- mem2proc_tag stays 0 through cycle 10;
- next LOAD 0x20 gets tag 1 and returns 0x55.
